// File: rtl/serial_subtractor_if.sv
// Start/done handshake and result bus for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_subtractor_if #(
   parameter int unsigned N = 16
) ();
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         borrow;
   logic         overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, overflow
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-adder slice adds ~b with a carry flop seeded to 1.
module serial_subtractor #(
   parameter int unsigned N = 16
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CntW = $clog2(N);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q;
   logic [N-1:0]    ar_q, br_q, res_q, diff_q;
   logic [CntW-1:0] count_q;
   logic            carry_q, a_msb_q, b_msb_q;
   logic            busy_q, done_q, borrow_q, overflow_q;

   logic         nb, s, cout;
   logic [N-1:0] res_next;

   always_comb begin
      nb       = ~br_q[0];
      s        = ar_q[0] ^ nb ^ carry_q;
      cout     = (ar_q[0] & nb) | (ar_q[0] & carry_q) | (nb & carry_q);
      res_next = {s, res_q[N-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ar_q       <= '0;
         br_q       <= '0;
         res_q      <= '0;
         diff_q     <= '0;
         count_q    <= '0;
         carry_q    <= 1'b0;
         a_msb_q    <= 1'b0;
         b_msb_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  ar_q    <= bus.a;
                  br_q    <= bus.b;
                  a_msb_q <= bus.a[N-1];
                  b_msb_q <= bus.b[N-1];
                  carry_q <= 1'b1;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StShift;
               end else begin
                  state_q <= StIdle;
               end
            end
            StShift: begin
               carry_q <= cout;
               res_q   <= res_next;
               ar_q    <= {1'b0, ar_q[N-1:1]};
               br_q    <= {1'b0, br_q[N-1:1]};
               count_q <= count_q + 1'b1;
               if (count_q == LastCnt) begin
                  // Result and flags are published only on the edge entering DONE.
                  diff_q     <= res_next;
                  borrow_q   <= ~cout;
                  overflow_q <= (a_msb_q != b_msb_q) && (s != a_msb_q);
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.diff     = diff_q;
   assign bus.borrow   = borrow_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: N=16 directed scenarios plus an exhaustive N=4 sweep.
module tb_serial_subtractor;
   typedef struct packed {
      logic [15:0] diff;
      logic        borrow;
      logic        overflow;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t sb4[$];

   always #5 clk = ~clk;

   serial_subtractor_if #(.N(16)) bus ();
   serial_subtractor_if #(.N(4))  bus4 ();

   serial_subtractor #(.N(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   serial_subtractor #(.N(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e.diff     = a - b;
      e.borrow   = (a < b);
      e.overflow = (a[15] != b[15]) && (e.diff[15] != a[15]);
      return e;
   endfunction

   function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b);
      exp_t       e;
      logic [3:0] d;
      d          = a - b;
      e.diff     = {12'h000, d};
      e.borrow   = (a < b);
      e.overflow = (a[3] != b[3]) && (d[3] != a[3]);
      return e;
   endfunction

   // Caller must be at a negedge; leaves us at the negedge after the accepting edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      bus.a = a;
      bus.b = b;
      bus.start = 1'b1;
      sb.push_back(model16(a, b));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
   endtask

   task automatic wait_done(output int edges, output int busy_cnt, output bit ok);
      edges = 1;
      busy_cnt = 0;
      while (!bus.done && edges < 64) begin
         if (bus.busy) busy_cnt++;
         @(negedge clk);
         edges++;
      end
      ok = bus.done;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      total++; if (bus.diff !== 16'h0) begin bad++; $display("FAIL reset_diff got=%h want=0000", bus.diff); end
      total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b want=0", bus.borrow); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
   endtask

   task automatic test_basic();
      logic [15:0] av[5] = '{16'd5, 16'd3, 16'd0, 16'h8000, 16'h7FFF};
      logic [15:0] bv[5] = '{16'd3, 16'd5, 16'd1, 16'h0001, 16'hFFFF};
      int edges, busy_cnt;
      bit ok;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         start_op(av[i], bv[i]);
         wait_done(edges, busy_cnt, ok);
         e = sb.pop_front();
         total++; if (!ok) begin bad++; $display("FAIL basic%0d_timeout edges=%0d", i, edges); end
         if (i == 0) begin
            total++; if (edges != 17) begin bad++; $display("FAIL latency got=%0d want=17", edges); end
            total++; if (busy_cnt != 16) begin bad++; $display("FAIL busy_cycles got=%0d want=16", busy_cnt); end
         end
         total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic%0d_busy_at_done got=%b want=0", i, bus.busy); end
         total++; if (bus.diff !== e.diff) begin bad++; $display("FAIL basic%0d_diff got=%h want=%h", i, bus.diff, e.diff); end
         total++; if (bus.borrow !== e.borrow) begin bad++; $display("FAIL basic%0d_borrow got=%b want=%b", i, bus.borrow, e.borrow); end
         total++; if (bus.overflow !== e.overflow) begin bad++; $display("FAIL basic%0d_ovf got=%b want=%b", i, bus.overflow, e.overflow); end
         @(negedge clk);
         total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic%0d_done_pulse got=%b want=0", i, bus.done); end
         total++; if (bus.diff !== e.diff) begin bad++; $display("FAIL basic%0d_hold got=%h want=%h", i, bus.diff, e.diff); end
      end
   endtask

   task automatic test_reset_mid_op();
      int edges, busy_cnt, dones;
      bit ok;
      exp_t e;
      start_op(16'd100, 16'd1);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
      total++; if (bus.diff !== 16'h0) begin bad++; $display("FAIL rstmid_diff got=%h want=0000", bus.diff); end
      total++; if (bus.borrow !== 1'b0 || bus.overflow !== 1'b0) begin
         bad++; $display("FAIL rstmid_flags got=%b%b want=00", bus.borrow, bus.overflow);
      end
      dones = 0;
      repeat (24) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      total++; if (dones != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
      start_op(16'd2, 16'd2);
      wait_done(edges, busy_cnt, ok);
      e = sb.pop_front();
      total++; if (!ok) begin bad++; $display("FAIL rstmid_restart_timeout edges=%0d", edges); end
      total++; if (bus.diff !== e.diff || bus.borrow !== e.borrow) begin
         bad++; $display("FAIL rstmid_restart got=%h/%b want=%h/%b", bus.diff, bus.borrow, e.diff, e.borrow);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int edges, busy_cnt, dones;
      bit ok;
      exp_t e;
      start_op(16'd9, 16'd4);
      repeat (4) @(negedge clk);
      bus.a = 16'd1; bus.b = 16'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(edges, busy_cnt, ok);
      e = sb.pop_front();
      total++; if (!ok) begin bad++; $display("FAIL hs_first_timeout edges=%0d", edges); end
      total++; if (bus.diff !== e.diff) begin bad++; $display("FAIL hs_ignored_diff got=%h want=%h", bus.diff, e.diff); end
      // Still in the DONE cycle: a new request here must be accepted.
      start_op(16'd7, 16'd7);
      wait_done(edges, busy_cnt, ok);
      e = sb.pop_front();
      total++; if (!ok || edges != 17) begin bad++; $display("FAIL hs_done_start edges=%0d want=17", edges); end
      total++; if (bus.diff !== e.diff || bus.borrow !== e.borrow) begin
         bad++; $display("FAIL hs_second got=%h/%b want=%h/%b", bus.diff, bus.borrow, e.diff, e.borrow);
      end
      dones = 0;
      @(negedge clk);
      repeat (24) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      total++; if (dones != 0) begin bad++; $display("FAIL hs_not_queued got=%0d want=0", dones); end
   endtask

   task automatic test_exhaustive_n4();
      int   waited;
      exp_t e;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            bus4.a = 4'(ia);
            bus4.b = 4'(ib);
            bus4.start = 1'b1;
            sb4.push_back(model4(4'(ia), 4'(ib)));
            @(negedge clk);
            bus4.start = 1'b0;
            bus4.a = 4'($urandom);
            bus4.b = 4'($urandom);
            waited = 0;
            while (!bus4.done && waited < 16) begin
               @(negedge clk);
               waited++;
            end
            e = sb4.pop_front();
            total++;
            if (!bus4.done || bus4.diff !== e.diff[3:0] || bus4.borrow !== e.borrow ||
                bus4.overflow !== e.overflow) begin
               bad++;
               $display("FAIL n4 a=%0d b=%0d got=%h/%b/%b done=%b want=%h/%b/%b", ia, ib, bus4.diff,
                        bus4.borrow, bus4.overflow, bus4.done, e.diff[3:0], e.borrow, e.overflow);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_reset_mid_op();
      test_back_to_back();
      test_exhaustive_n4();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
